// File: rtl/traffic_signal_ctrl_n.sv
// N-approach traffic signal controller: road 0 is main (default green), roads 1..N-1 are sensor-driven, served round-robin.
// Optional pedestrian walk phase is compiled in with `define TSC_PED_EN.
module traffic_signal_ctrl_n #(
  parameter int N_ROADS   = 3,
  parameter int CNT_W     = 8,
  parameter int MIN_GREEN = 8,
  parameter int MAX_GREEN = 32,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 2,
  parameter int PED_T     = 6
) (
  input  logic                       clk,
  input  logic                       clear,
  input  logic [N_ROADS-1:0]         car_on_rd,
`ifdef TSC_PED_EN
  input  logic                       ped_req,
  output logic                       ped_walk,
`endif
  output logic [2*N_ROADS-1:0]       sig,
  output logic [$clog2(N_ROADS)-1:0] active_rd
);

  localparam int AW = $clog2(N_ROADS);
  localparam logic [1:0] LAMP_YEL = 2'd1;
  localparam logic [1:0] LAMP_GRN = 2'd2;
  localparam logic [CNT_W-1:0] CNT_SAT = '1;
  localparam logic [CNT_W-1:0] MIN_C   = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] YEL_C   = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] AR_C    = CNT_W'(ALLRED_T - 1);

  if (N_ROADS < 2 || MIN_GREEN < 1 || MAX_GREEN < MIN_GREEN || YELLOW_T < 1 || ALLRED_T < 1 ||
      PED_T < 1 || MAX_GREEN > 2**CNT_W - 1 || PED_T > 2**CNT_W - 1) begin : g_bad_cfg
    $error("traffic_signal_ctrl_n: illegal parameter combination");
  end

`ifdef TSC_PED_EN
  typedef enum logic [1:0] {S_GREEN, S_YELLOW, S_ALLRED, S_PED} state_t;
  localparam logic [CNT_W-1:0] PED_C = CNT_W'(PED_T - 1);
  logic ped_pend, ped_pend_nxt;
`else
  typedef enum logic [1:0] {S_GREEN, S_YELLOW, S_ALLRED} state_t;
`endif

  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       cnt;
  logic [N_ROADS-1:0]     req, req_nxt, req_other;
  logic [AW-1:0]          next_rd, next_sel, active_nxt, pick;
  logic [2*N_ROADS-1:0]   sig_nxt;
  logic                   other_req, found, exit_cond;
  int                     idx;

  // Round-robin search starting just after the current road; falls back to the main road.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k < N_ROADS; k++) begin
      idx = int'(active_rd) + k;
      if (idx >= N_ROADS) idx = idx - N_ROADS;
      if (!found && req[idx[AW-1:0]]) begin
        pick  = idx[AW-1:0];
        found = 1'b1;
      end
    end
  end

  always_comb begin
    req_other            = req;
    req_other[active_rd] = 1'b0;
    other_req            = |req_other;
  end

  always_comb begin
    exit_cond = (active_rd == '0 && other_req) ||
                (active_rd != '0 && !car_on_rd[active_rd]) ||
                (other_req && cnt == MAX_C);
`ifdef TSC_PED_EN
    exit_cond = exit_cond || ped_pend;
`endif
  end

  always_comb begin
    state_nxt  = state;
    active_nxt = active_rd;
    next_sel   = next_rd;
    case (state)
      S_GREEN: if (cnt >= MIN_C && exit_cond) begin
        state_nxt = S_YELLOW;
        next_sel  = pick;
      end
      S_YELLOW: if (cnt == YEL_C) state_nxt = S_ALLRED;
      S_ALLRED: if (cnt == AR_C) begin
`ifdef TSC_PED_EN
        if (ped_pend) begin
          state_nxt = S_PED;
        end else begin
          state_nxt  = S_GREEN;
          active_nxt = next_rd;
        end
`else
        state_nxt  = S_GREEN;
        active_nxt = next_rd;
`endif
      end
`ifdef TSC_PED_EN
      S_PED: if (cnt == PED_C) state_nxt = S_ALLRED;
`endif
      default: state_nxt = S_GREEN;
    endcase
  end

  // Latch sensor hits; the clear on green entry takes priority over a simultaneous hit.
  always_comb begin
    req_nxt = req;
    for (int i = 1; i < N_ROADS; i++) begin
      if (car_on_rd[i] && (AW'(i) != active_rd || state != S_GREEN)) req_nxt[i] = 1'b1;
    end
    if (state != S_GREEN && state_nxt == S_GREEN) req_nxt[active_nxt] = 1'b0;
    req_nxt[0] = 1'b0;
  end

  always_comb begin
    sig_nxt = '0;
    for (int i = 0; i < N_ROADS; i++) begin
      if (AW'(i) == active_nxt) begin
        if (state_nxt == S_GREEN)  sig_nxt[2*i +: 2] = LAMP_GRN;
        if (state_nxt == S_YELLOW) sig_nxt[2*i +: 2] = LAMP_YEL;
      end
    end
  end

`ifdef TSC_PED_EN
  always_comb begin
    ped_pend_nxt = ped_pend | ped_req;
    if (state != S_PED && state_nxt == S_PED) ped_pend_nxt = 1'b0;
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      ped_pend <= 1'b0;
      ped_walk <= 1'b0;
    end else begin
      ped_pend <= ped_pend_nxt;
      ped_walk <= (state_nxt == S_PED);
    end
  end
`endif

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state     <= S_GREEN;
      cnt       <= '0;
      req       <= '0;
      next_rd   <= '0;
      active_rd <= '0;
      sig       <= {{(2*N_ROADS-2){1'b0}}, LAMP_GRN};
    end else begin
      state     <= state_nxt;
      req       <= req_nxt;
      next_rd   <= next_sel;
      active_rd <= active_nxt;
      sig       <= sig_nxt;
      if (state_nxt != state)  cnt <= '0;
      else if (cnt != CNT_SAT) cnt <= cnt + 1'b1;
    end
  end

endmodule
